// File: rtl/axi2iob_pkg.sv
// Shared AXI field widths and encodings for the AXI4 slave to native-bus bridge.
package axi2iob_pkg;

   localparam int AXI_LEN_W   = 8;
   localparam int AXI_SIZE_W  = 3;
   localparam int AXI_BURST_W = 2;
   localparam int AXI_RESP_W  = 2;

   typedef enum logic [AXI_BURST_W-1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_e;

   localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;

   // Largest legal AWSIZE/ARSIZE for a data bus of data_w bits.
   function automatic logic [AXI_SIZE_W-1:0] max_size(input int data_w);
      return AXI_SIZE_W'($clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/axi2iob_addr_gen.sv
// Next-beat address and burst-legality check, shared by the read and write paths.
module axi2iob_addr_gen
   import axi2iob_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic [ADDR_W-1:0]      addr,
   input  logic [AXI_SIZE_W-1:0]  size,
   input  logic [AXI_BURST_W-1:0] burst,
   output logic [ADDR_W-1:0]      next_addr,
   output logic                   cfg_err
);

   always_comb begin
      cfg_err = (burst == BURST_WRAP) || (burst == BURST_RSVD) || (size > max_size(DATA_W));
      // FIXED repeats the address; the carry out of INCR is dropped (wraps modulo 2^ADDR_W).
      if (burst == BURST_INCR)
         next_addr = addr + (ADDR_W'(1) << size);
      else
         next_addr = addr;
   end

endmodule

// File: rtl/axi2iob.sv
// AXI4-Full slave to native-bus master bridge: one burst at a time, one native access per beat.
module axi2iob
   import axi2iob_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int AXI_ID_W = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   // write address
   input  logic [AXI_ID_W-1:0]    s_axi_awid,
   input  logic [ADDR_W-1:0]      s_axi_awaddr,
   input  logic [AXI_LEN_W-1:0]   s_axi_awlen,
   input  logic [AXI_SIZE_W-1:0]  s_axi_awsize,
   input  logic [AXI_BURST_W-1:0] s_axi_awburst,
   input  logic                   s_axi_awvalid,
   output logic                   s_axi_awready,
   // write data
   input  logic [DATA_W-1:0]      s_axi_wdata,
   input  logic [DATA_W/8-1:0]    s_axi_wstrb,
   input  logic                   s_axi_wlast,
   input  logic                   s_axi_wvalid,
   output logic                   s_axi_wready,
   // write response
   output logic [AXI_ID_W-1:0]    s_axi_bid,
   output logic [AXI_RESP_W-1:0]  s_axi_bresp,
   output logic                   s_axi_bvalid,
   input  logic                   s_axi_bready,
   // read address
   input  logic [AXI_ID_W-1:0]    s_axi_arid,
   input  logic [ADDR_W-1:0]      s_axi_araddr,
   input  logic [AXI_LEN_W-1:0]   s_axi_arlen,
   input  logic [AXI_SIZE_W-1:0]  s_axi_arsize,
   input  logic [AXI_BURST_W-1:0] s_axi_arburst,
   input  logic                   s_axi_arvalid,
   output logic                   s_axi_arready,
   // read data
   output logic [AXI_ID_W-1:0]    s_axi_rid,
   output logic [DATA_W-1:0]      s_axi_rdata,
   output logic [AXI_RESP_W-1:0]  s_axi_rresp,
   output logic                   s_axi_rlast,
   output logic                   s_axi_rvalid,
   input  logic                   s_axi_rready,
   // native master
   output logic                   m_valid,
   output logic [ADDR_W-1:0]      m_addr,
   output logic [DATA_W-1:0]      m_wdata,
   output logic [DATA_W/8-1:0]    m_wstrb,
   input  logic [DATA_W-1:0]      m_rdata,
   input  logic                   m_ready
);

   typedef enum logic [2:0] {
      IDLE, WR_DATA, WR_ACC, WR_RESP, RD_ACC, RD_DATA
   } state_e;

   state_e state, state_nxt;

   logic                   last_wr;
   logic [AXI_ID_W-1:0]    id;
   logic [ADDR_W-1:0]      addr;
   logic [AXI_LEN_W-1:0]   len;
   logic [AXI_LEN_W-1:0]   cnt;
   logic [AXI_SIZE_W-1:0]  size;
   logic [AXI_BURST_W-1:0] burst;
   logic                   err;

   logic                   aw_sel, ar_sel;
   logic                   aw_hs, ar_hs, w_hs;
   logic                   last_beat, wlast_err, w_skip;
   logic [ADDR_W-1:0]      gen_addr, next_addr;
   logic [AXI_SIZE_W-1:0]  gen_size;
   logic [AXI_BURST_W-1:0] gen_burst;
   logic                   gen_err;

   // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
   always_comb begin
      // On a tie, serve the channel that did not win last time.
      aw_sel        = s_axi_awvalid && (!s_axi_arvalid || !last_wr);
      ar_sel        = s_axi_arvalid && !aw_sel;
      s_axi_awready = !rst && (state == IDLE) && aw_sel;
      s_axi_arready = !rst && (state == IDLE) && ar_sel;
      s_axi_wready  = (state == WR_DATA);
      aw_hs         = s_axi_awready;
      ar_hs         = s_axi_arready;
      w_hs          = s_axi_wvalid && s_axi_wready;
      last_beat     = (cnt == len);
      wlast_err     = (s_axi_wlast != last_beat);
      // A zero-strobe beat would look like a read natively, so it is retired without an access.
      w_skip        = err || wlast_err || (s_axi_wstrb == '0);

      // In IDLE the checker looks at the incoming request so err is known at the handshake.
      gen_addr  = addr;
      gen_size  = size;
      gen_burst = burst;
      if (state == IDLE) begin
         if (aw_sel) begin
            gen_addr  = s_axi_awaddr;
            gen_size  = s_axi_awsize;
            gen_burst = s_axi_awburst;
         end else begin
            gen_addr  = s_axi_araddr;
            gen_size  = s_axi_arsize;
            gen_burst = s_axi_arburst;
         end
      end
   end

   axi2iob_addr_gen #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_addr_gen (
      .addr      (gen_addr),
      .size      (gen_size),
      .burst     (gen_burst),
      .next_addr (next_addr),
      .cfg_err   (gen_err)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (aw_hs)
               state_nxt = WR_DATA;
            else if (ar_hs)
               state_nxt = RD_ACC;
         end
         WR_DATA: begin
            if (w_hs) begin
               if (!w_skip)
                  state_nxt = WR_ACC;
               else if (last_beat)
                  state_nxt = WR_RESP;
            end
         end
         WR_ACC: begin
            if (m_ready)
               state_nxt = last_beat ? WR_RESP : WR_DATA;
         end
         WR_RESP: begin
            if (s_axi_bready)
               state_nxt = IDLE;
         end
         RD_ACC: begin
            if (err || m_ready)
               state_nxt = RD_DATA;
         end
         RD_DATA: begin
            if (s_axi_rready)
               state_nxt = s_axi_rlast ? IDLE : RD_ACC;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_wr      <= 1'b0;
         id           <= '0;
         addr         <= '0;
         len          <= '0;
         cnt          <= '0;
         size         <= '0;
         burst        <= '0;
         err          <= 1'b0;
         m_valid      <= 1'b0;
         m_addr       <= '0;
         m_wdata      <= '0;
         m_wstrb      <= '0;
         s_axi_bvalid <= 1'b0;
         s_axi_bid    <= '0;
         s_axi_bresp  <= '0;
         s_axi_rvalid <= 1'b0;
         s_axi_rid    <= '0;
         s_axi_rdata  <= '0;
         s_axi_rresp  <= '0;
         s_axi_rlast  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (aw_hs) begin
                  last_wr <= 1'b1;
                  id      <= s_axi_awid;
                  addr    <= s_axi_awaddr;
                  len     <= s_axi_awlen;
                  size    <= s_axi_awsize;
                  burst   <= s_axi_awburst;
                  cnt     <= '0;
                  err     <= gen_err;
               end else if (ar_hs) begin
                  last_wr <= 1'b0;
                  id      <= s_axi_arid;
                  addr    <= s_axi_araddr;
                  len     <= s_axi_arlen;
                  size    <= s_axi_arsize;
                  burst   <= s_axi_arburst;
                  cnt     <= '0;
                  err     <= gen_err;
                  if (!gen_err) begin
                     m_valid <= 1'b1;
                     m_addr  <= s_axi_araddr;
                     m_wstrb <= '0;
                  end
               end
            end
            WR_DATA: begin
               if (w_hs) begin
                  if (wlast_err)
                     err <= 1'b1;
                  if (!w_skip) begin
                     m_valid <= 1'b1;
                     m_addr  <= addr;
                     m_wdata <= s_axi_wdata;
                     m_wstrb <= s_axi_wstrb;
                  end else if (!last_beat) begin
                     addr <= next_addr;
                     cnt  <= cnt + AXI_LEN_W'(1);
                  end else begin
                     s_axi_bvalid <= 1'b1;
                     s_axi_bid    <= id;
                     s_axi_bresp  <= (err || wlast_err) ? RESP_SLVERR : RESP_OKAY;
                  end
               end
            end
            WR_ACC: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  if (last_beat) begin
                     s_axi_bvalid <= 1'b1;
                     s_axi_bid    <= id;
                     s_axi_bresp  <= err ? RESP_SLVERR : RESP_OKAY;
                  end else begin
                     addr <= next_addr;
                     cnt  <= cnt + AXI_LEN_W'(1);
                  end
               end
            end
            WR_RESP: begin
               if (s_axi_bready)
                  s_axi_bvalid <= 1'b0;
            end
            RD_ACC: begin
               if (err || m_ready) begin
                  m_valid      <= 1'b0;
                  s_axi_rvalid <= 1'b1;
                  s_axi_rid    <= id;
                  s_axi_rlast  <= last_beat;
                  s_axi_rdata  <= err ? '0 : m_rdata;
                  s_axi_rresp  <= err ? RESP_SLVERR : RESP_OKAY;
               end
            end
            RD_DATA: begin
               if (s_axi_rready) begin
                  s_axi_rvalid <= 1'b0;
                  if (!s_axi_rlast) begin
                     addr <= next_addr;
                     cnt  <= cnt + AXI_LEN_W'(1);
                     if (!err) begin
                        m_valid <= 1'b1;
                        m_addr  <= next_addr;
                        m_wstrb <= '0;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
